keypad_scan_ctrl: RTL and testbench

- Sequencer for the 4x4 keypad scan path. Generates its own scan tick, drives one-hot rows, and waits for column settling after each row change.
- Debounces press and release on the settled row and emits one registered key code plus a single-cycle valid pulse per physical press.
- Replaces the free-running row stepping and ad-hoc sampling. Feeds the digit-history and seven-segment display logic.

---
 rtl/keypad_scan_ctrl_if.sv | 19 +
 rtl/keypad_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan bus: scan enable and raw columns in, row drive and confirmed key out.
interface keypad_scan_ctrl_if;
  logic       scan_en;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output scan_en, col,
    input  row, key_code, key_valid, key_down
  );

  modport slave (
    input  scan_en, col,
    output row, key_code, key_valid, key_down
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: tick-paced row stepping, column settling, press/release
// debounce and a single-cycle key_valid per confirmed press.
module keypad_scan_ctrl #(
  parameter int TICK_DIV     = 2632,
  parameter int SETTLE_TICKS = 1,
  parameter int DB_TICKS     = 4
) (
  input logic               clk,
  input logic               reset,
  keypad_scan_ctrl_if.slave kp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    DEBOUNCE = 2'd2,
    PRESSED  = 2'd3
  } state_t;

  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_TICKS - 1);
  localparam logic [3:0]  DB_LAST     = 4'(DB_TICKS - 1);

  function automatic logic [1:0] col_winner(input logic [3:0] c);
    logic [1:0] w;
    if (c[3]) begin
      w = 2'd3;
    end else if (c[2]) begin
      w = 2'd2;
    end else if (c[1]) begin
      w = 2'd1;
    end else begin
      w = 2'd0;
    end
    return w;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] row_advance(input logic [3:0] r);
    logic [3:0] nxt;
    case (r)
      4'b0001: nxt = 4'b0010;
      4'b0010: nxt = 4'b0100;
      4'b0100: nxt = 4'b1000;
      default: nxt = 4'b0001;
    endcase
    return nxt;
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  logic [15:0] tick_cnt_r;
  logic        tick_s;
  logic [3:0]  col_meta_r;
  logic [3:0]  col_sync_r;
  logic        col_any_s;
  logic [1:0]  win_s;

  state_t      state_r,      state_nxt_s;
  logic [3:0]  row_r,        row_nxt_s;
  logic [3:0]  settle_cnt_r, settle_cnt_nxt_s;
  logic [3:0]  db_cnt_r,     db_cnt_nxt_s;
  logic [3:0]  rel_cnt_r,    rel_cnt_nxt_s;
  logic [1:0]  cand_win_r,   cand_win_nxt_s;
  logic [3:0]  key_code_r,   key_code_nxt_s;
  logic        key_valid_r,  key_valid_nxt_s;
  logic        key_down_r,   key_down_nxt_s;

  // Scan tick divider, parked at zero while scanning is disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= 16'd0;
    end else if (!kp.scan_en) begin
      tick_cnt_r <= 16'd0;
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= 16'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 16'd1;
    end
  end

  assign tick_s = kp.scan_en && (tick_cnt_r == TICK_LAST);

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_r <= 4'b0000;
      col_sync_r <= 4'b0000;
    end else begin
      col_meta_r <= kp.col;
      col_sync_r <= col_meta_r;
    end
  end

  assign col_any_s = |col_sync_r;
  assign win_s     = col_winner(col_sync_r);

  // FSM and registered output state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      row_r        <= 4'b0001;
      settle_cnt_r <= 4'd0;
      db_cnt_r     <= 4'd0;
      rel_cnt_r    <= 4'd0;
      cand_win_r   <= 2'd0;
      key_code_r   <= 4'h0;
      key_valid_r  <= 1'b0;
      key_down_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      row_r        <= row_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      db_cnt_r     <= db_cnt_nxt_s;
      rel_cnt_r    <= rel_cnt_nxt_s;
      cand_win_r   <= cand_win_nxt_s;
      key_code_r   <= key_code_nxt_s;
      key_valid_r  <= key_valid_nxt_s;
      key_down_r   <= key_down_nxt_s;
    end
  end

  // Next-state logic; everything except the scan_en drop waits for a tick
  always_comb begin
    state_nxt_s      = state_r;
    row_nxt_s        = row_r;
    settle_cnt_nxt_s = settle_cnt_r;
    db_cnt_nxt_s     = db_cnt_r;
    rel_cnt_nxt_s    = rel_cnt_r;
    cand_win_nxt_s   = cand_win_r;
    key_code_nxt_s   = key_code_r;
    key_valid_nxt_s  = 1'b0;
    key_down_nxt_s   = key_down_r;

    if (!kp.scan_en) begin
      state_nxt_s      = IDLE;
      row_nxt_s        = 4'b0000;
      settle_cnt_nxt_s = 4'd0;
      db_cnt_nxt_s     = 4'd0;
      rel_cnt_nxt_s    = 4'd0;
      key_down_nxt_s   = 1'b0;
    end else if (tick_s) begin
      case (state_r)
        IDLE: begin
          state_nxt_s      = SETTLE;
          row_nxt_s        = 4'b0001;
          settle_cnt_nxt_s = 4'd0;
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_nxt_s = 4'd0;
            if (col_any_s) begin
              cand_win_nxt_s = win_s;
              db_cnt_nxt_s   = 4'd1;
              // A single-sample debounce confirms on the settle sample itself
              if (DB_TICKS == 1) begin
                state_nxt_s     = PRESSED;
                key_code_nxt_s  = key_lookup(row_index(row_r), win_s);
                key_valid_nxt_s = 1'b1;
                key_down_nxt_s  = 1'b1;
                rel_cnt_nxt_s   = 4'd0;
              end else begin
                state_nxt_s = DEBOUNCE;
              end
            end else begin
              row_nxt_s = row_advance(row_r);
            end
          end else begin
            settle_cnt_nxt_s = settle_cnt_r + 4'd1;
          end
        end
        DEBOUNCE: begin
          if (col_any_s && (win_s == cand_win_r)) begin
            if (db_cnt_r == DB_LAST) begin
              state_nxt_s     = PRESSED;
              key_code_nxt_s  = key_lookup(row_index(row_r), cand_win_r);
              key_valid_nxt_s = 1'b1;
              key_down_nxt_s  = 1'b1;
              rel_cnt_nxt_s   = 4'd0;
            end else begin
              db_cnt_nxt_s = db_cnt_r + 4'd1;
            end
          end else begin
            state_nxt_s      = SETTLE;
            settle_cnt_nxt_s = 4'd0;
            db_cnt_nxt_s     = 4'd0;
          end
        end
        PRESSED: begin
          if (!col_any_s) begin
            if (rel_cnt_r == DB_LAST) begin
              state_nxt_s      = SETTLE;
              row_nxt_s        = row_advance(row_r);
              settle_cnt_nxt_s = 4'd0;
              rel_cnt_nxt_s    = 4'd0;
              key_down_nxt_s   = 1'b0;
            end else begin
              rel_cnt_nxt_s = rel_cnt_r + 4'd1;
            end
          end else begin
            rel_cnt_nxt_s = 4'd0;
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          row_nxt_s      = 4'b0000;
          key_down_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign kp.row       = row_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with TICK_DIV=4, SETTLE_TICKS=1, DB_TICKS=3.
// Ticks fall on every 4th clk edge after reset release (P4, P8, ...).
module tb_keypad_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   kv_count    = 0;
  int   kv_double   = 0;
  logic kv_prev     = 1'b0;

  keypad_scan_ctrl_if kp();

  keypad_scan_ctrl #(
    .TICK_DIV(4),
    .SETTLE_TICKS(1),
    .DB_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  always #5 clk = ~clk;

  // Count key_valid pulses and back-to-back pulses
  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      kv_count <= kv_count + 1;
      if (kv_prev) kv_double <= kv_double + 1;
    end
    kv_prev <= kp.key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; kp.scan_en = 1'b1; kp.col = 4'b0000;
    step(3);
    vectors++; if (kp.row !== 4'b0001) begin miscompares++; $display("FAIL reset_row got %b expected 0001", kp.row); end
    vectors++; if (kp.key_code !== 4'h0) begin miscompares++; $display("FAIL reset_code got %h expected 0", kp.key_code); end
    vectors++; if (kp.key_valid !== 1'b0 || kp.key_down !== 1'b0) begin miscompares++; $display("FAIL reset_flags got valid=%b down=%b expected 0 0", kp.key_valid, kp.key_down); end
    reset = 1'b1;
    step(7);
    vectors++; if (kp.row !== 4'b0001) begin miscompares++; $display("FAIL idle_row_p7 got %b expected 0001", kp.row); end
    step(1);
    vectors++; if (kp.row !== 4'b0010) begin miscompares++; $display("FAIL step_row_p8 got %b expected 0010", kp.row); end
    step(4);
    vectors++; if (kp.row !== 4'b0100) begin miscompares++; $display("FAIL step_row_p12 got %b expected 0100", kp.row); end
    step(4);
    vectors++; if (kp.row !== 4'b1000) begin miscompares++; $display("FAIL step_row_p16 got %b expected 1000", kp.row); end
    step(4);
    vectors++; if (kp.row !== 4'b0001) begin miscompares++; $display("FAIL step_row_p20 got %b expected 0001", kp.row); end
    vectors++; if (kv_count !== 0 || kp.key_code !== 4'h0) begin miscompares++; $display("FAIL idle_no_key got pulses=%0d code=%h expected 0 0", kv_count, kp.key_code); end
  endtask

  task automatic test_clean_press;
    int base;
    base = kv_count;
    step(4);
    vectors++; if (kp.row !== 4'b0010) begin miscompares++; $display("FAIL press_row_p24 got %b expected 0010", kp.row); end
    kp.col = 4'b0100;
    step(11);
    vectors++; if (kp.key_valid !== 1'b0 || kp.row !== 4'b0010) begin miscompares++; $display("FAIL press_early got valid=%b row=%b expected 0 0010", kp.key_valid, kp.row); end
    step(1);
    vectors++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'h6 || kp.key_down !== 1'b1) begin miscompares++; $display("FAIL press_key6 got valid=%b code=%h down=%b expected 1 6 1", kp.key_valid, kp.key_code, kp.key_down); end
    step(1);
    vectors++; if (kp.key_valid !== 1'b0 || kp.key_down !== 1'b1) begin miscompares++; $display("FAIL press_pulse_width got valid=%b down=%b expected 0 1", kp.key_valid, kp.key_down); end
    kp.col = 4'b0000;
    step(10);
    vectors++; if (kp.key_down !== 1'b1 || kp.row !== 4'b0010) begin miscompares++; $display("FAIL release_early got down=%b row=%b expected 1 0010", kp.key_down, kp.row); end
    step(1);
    vectors++; if (kp.key_down !== 1'b0 || kp.row !== 4'b0100) begin miscompares++; $display("FAIL release_done got down=%b row=%b expected 0 0100", kp.key_down, kp.row); end
    vectors++; if (kv_count - base !== 1) begin miscompares++; $display("FAIL press_pulse_count got %0d expected 1", kv_count - base); end
  endtask

  task automatic test_bounce;
    int base;
    base = kv_count;
    step(4);
    vectors++; if (kp.row !== 4'b1000) begin miscompares++; $display("FAIL bounce_row_p52 got %b expected 1000", kp.row); end
    kp.col = 4'b0001;
    step(4);
    kp.col = 4'b0000;
    step(4);
    vectors++; if (kp.row !== 4'b1000 || kv_count !== base) begin miscompares++; $display("FAIL bounce_hold got row=%b pulses=%0d expected 1000 %0d", kp.row, kv_count, base); end
    kp.col = 4'b0001;
    step(11);
    vectors++; if (kp.key_valid !== 1'b0 || kv_count !== base) begin miscompares++; $display("FAIL bounce_early got valid=%b pulses=%0d expected 0 %0d", kp.key_valid, kv_count, base); end
    step(1);
    vectors++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'hE || kp.row !== 4'b1000) begin miscompares++; $display("FAIL bounce_keyE got valid=%b code=%h row=%b expected 1 e 1000", kp.key_valid, kp.key_code, kp.row); end
    step(1);
    kp.col = 4'b0000;
    step(11);
    vectors++; if (kp.row !== 4'b0001 || kp.key_down !== 1'b0) begin miscompares++; $display("FAIL bounce_release got row=%b down=%b expected 0001 0", kp.row, kp.key_down); end
    vectors++; if (kv_count - base !== 1) begin miscompares++; $display("FAIL bounce_pulse_count got %0d expected 1", kv_count - base); end
  endtask

  task automatic test_multi_key;
    int base;
    base = kv_count;
    kp.col = 4'b1010;
    step(12);
    vectors++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'hA) begin miscompares++; $display("FAIL multi_keyA got valid=%b code=%h expected 1 a", kp.key_valid, kp.key_code); end
    step(1);
    kp.col = 4'b1011;
    step(6);
    kp.col = 4'b0001;
    step(6);
    vectors++; if (kv_count - base !== 1 || kp.key_code !== 4'hA) begin miscompares++; $display("FAIL multi_no_second got pulses=%0d code=%h expected 1 a", kv_count - base, kp.key_code); end
    vectors++; if (kp.key_down !== 1'b1 || kp.row !== 4'b0001) begin miscompares++; $display("FAIL multi_held got down=%b row=%b expected 1 0001", kp.key_down, kp.row); end
    kp.col = 4'b0000;
    step(11);
    vectors++; if (kp.row !== 4'b0010 || kp.key_down !== 1'b0) begin miscompares++; $display("FAIL multi_release got row=%b down=%b expected 0010 0", kp.row, kp.key_down); end
  endtask

  task automatic test_scan_en_drop;
    int base;
    base = kv_count;
    kp.col = 4'b0010;
    step(4);
    kp.scan_en = 1'b0;
    step(1);
    vectors++; if (kp.row !== 4'b0000 || kp.key_down !== 1'b0 || kp.key_valid !== 1'b0) begin miscompares++; $display("FAIL drop_idle got row=%b down=%b valid=%b expected 0000 0 0", kp.row, kp.key_down, kp.key_valid); end
    vectors++; if (kp.key_code !== 4'hA) begin miscompares++; $display("FAIL drop_code_kept got %h expected a", kp.key_code); end
    kp.col = 4'b0000;
    step(6);
    kp.scan_en = 1'b1;
    step(3);
    vectors++; if (kp.row !== 4'b0000) begin miscompares++; $display("FAIL reenable_wait got %b expected 0000", kp.row); end
    step(1);
    vectors++; if (kp.row !== 4'b0001) begin miscompares++; $display("FAIL reenable_row got %b expected 0001", kp.row); end
    vectors++; if (kv_count !== base) begin miscompares++; $display("FAIL drop_no_pulse got %0d expected %0d", kv_count, base); end
  endtask

  task automatic test_async_reset;
    step(4);
    vectors++; if (kp.row !== 4'b0010) begin miscompares++; $display("FAIL areset_row_p139 got %b expected 0010", kp.row); end
    kp.col = 4'b0010;
    step(12);
    vectors++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'h5 || kp.key_down !== 1'b1) begin miscompares++; $display("FAIL areset_key5 got valid=%b code=%h down=%b expected 1 5 1", kp.key_valid, kp.key_code, kp.key_down); end
    step(1);
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (kp.key_down !== 1'b0 || kp.row !== 4'b0001 || kp.key_code !== 4'h0) begin miscompares++; $display("FAIL areset_immediate got down=%b row=%b code=%h expected 0 0001 0", kp.key_down, kp.row, kp.key_code); end
    step(2);
    vectors++; if (kp.key_valid !== 1'b0 || kp.row !== 4'b0001) begin miscompares++; $display("FAIL areset_hold got valid=%b row=%b expected 0 0001", kp.key_valid, kp.row); end
    kp.col = 4'b0000;
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_back_to_back;
    vectors++; if (kv_double !== 0) begin miscompares++; $display("FAIL back_to_back_pulses got %0d expected 0", kv_double); end
    vectors++; if (kv_count !== 4) begin miscompares++; $display("FAIL total_pulses got %0d expected 4", kv_count); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_scan_en_drop();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
